// File: rtl/game_flow_ctrl_if.sv
// Interface bundling the event inputs and status outputs of the brick-breaker
// game-flow controller. The master side is the top level (or a bench) that
// supplies game events; the slave side is the controller itself.
interface game_flow_ctrl_if #(
   parameter int SKILL_CH = 3
);

   logic                tick;
   logic                start_press;
   logic                pause_press;
   logic                bricks_empty;
   logic                ball_lost;
   logic [SKILL_CH-1:0] skill_req;
   logic [SKILL_CH-1:0] skill_active;

   logic [2:0]          state;
   logic [3:0]          stage;
   logic [2:0]          lives;
   logic [2:0]          skill_pts;
   logic [SKILL_CH-1:0] skill_grant;
   logic                load_stage;
   logic [15:0]         led;

   // Top-level view: drives events, observes the game status
   modport master (
      output tick, start_press, pause_press, bricks_empty, ball_lost,
             skill_req, skill_active,
      input  state, stage, lives, skill_pts, skill_grant, load_stage, led
   );

   // Controller view: consumes events, produces the game status
   modport slave (
      input  tick, start_press, pause_press, bricks_empty, ball_lost,
             skill_req, skill_active,
      output state, stage, lives, skill_pts, skill_grant, load_stage, led
   );

endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow controller for the brick-breaker top level.
// Owns the game state (MENU/WIN/LOSE/PLAY/CLEAR/PAUSE), the stage index, the
// life and skill-point counters, one-hot skill grants, the brick-map load
// pulse and the 16-bit LED status word. Everything advances only on cycles
// where tick is high; the grant and load pulses last exactly one clk cycle.
// Optional feature: define PAUSE_EN to enable the pause key and PAUSE state.
// Without PAUSE_EN the pause key is ignored and PAUSE is never entered.
module game_flow_ctrl #(
   parameter int NUM_STAGES   = 3,
   parameter int LIVES        = 5,
   parameter int SKILL_POINTS = 3,
   parameter int SKILL_CH     = 3,
   parameter int CLEAR_TICKS  = 20
) (
   input logic             clk,
   input logic             rst,
   game_flow_ctrl_if.slave flowBus
);

   typedef enum logic [2:0] {
      MENU  = 3'd0,
      WIN   = 3'd1,
      LOSE  = 3'd2,
      PLAY  = 3'd3,
      CLEAR = 3'd4,
      PAUSE = 3'd5
   } gameState_t;

   localparam int                CNT_W      = (CLEAR_TICKS > 1) ? $clog2(CLEAR_TICKS) : 1;
   localparam logic [CNT_W-1:0]  CLEAR_LAST = CNT_W'(CLEAR_TICKS - 1);
   localparam logic [3:0]        LAST_STAGE = 4'(NUM_STAGES - 1);
   localparam logic [2:0]        LIVES_INIT = 3'(LIVES);
   localparam logic [2:0]        PTS_INIT   = 3'(SKILL_POINTS);

   gameState_t          state_q,      state_d;
   logic [3:0]          stage_q,      stage_d;
   logic [2:0]          lives_q,      lives_d;
   logic [2:0]          skillPts_q,   skillPts_d;
   logic [SKILL_CH-1:0] skillGrant_q, skillGrant_d;
   logic                loadStage_q,  loadStage_d;
   logic [15:0]         led_q,        led_d;
   logic [CNT_W-1:0]    clearCnt_q,   clearCnt_d;

   logic [SKILL_CH-1:0] eligible;
   logic [SKILL_CH-1:0] lowestEligible;

`ifndef PAUSE_EN
   logic unusedPause;

   // The pause key has no function in a build without the pause feature
   assign unusedPause = flowBus.pause_press;
`endif

   // LED word: lives thermometer from bit 0 upward, LOSE on bit 6, WIN on
   // bit 7, stage index in [11:8], skill points as a thermometer filling
   // downward from bit 15. The whole word is dark while sitting in MENU.
   function automatic logic [15:0] composeLed(
      input gameState_t st,
      input logic [3:0] stg,
      input logic [2:0] lv,
      input logic [2:0] pts
   );
      logic [15:0] v;
      v = '0;
      if (st != MENU) begin
         for (int i = 0; i < 6; i++) begin
            if ((i < LIVES) && (i < int'(lv))) begin
               v[i] = 1'b1;
            end
         end
         v[6]    = (st == LOSE);
         v[7]    = (st == WIN);
         v[11:8] = stg;
         for (int i = 0; i < 4; i++) begin
            if (i < int'(pts)) begin
               v[15-i] = 1'b1;
            end
         end
      end
      return v;
   endfunction

   // Skill arbitration: a channel is eligible when it is requested and its
   // previous effect has finished; the two's-complement trick isolates the
   // lowest eligible channel so at most one grant is issued per tick.
   always_comb begin
      eligible       = flowBus.skill_req & ~flowBus.skill_active;
      lowestEligible = eligible & (~eligible + SKILL_CH'(1));
   end

   // Next-state logic for the whole game flow. Nothing moves unless tick is
   // high; the pulse outputs default to zero so they drop after one cycle.
   // Within PLAY the events are taken in strict priority order, so an event
   // that coincides with a state change is consumed only by the old state.
   always_comb begin
      state_d      = state_q;
      stage_d      = stage_q;
      lives_d      = lives_q;
      skillPts_d   = skillPts_q;
      clearCnt_d   = clearCnt_q;
      skillGrant_d = '0;
      loadStage_d  = 1'b0;
      led_d        = led_q;

      if (flowBus.tick) begin
         case (state_q)
            MENU: begin
               if (flowBus.start_press) begin
                  state_d     = PLAY;
                  stage_d     = 4'd0;
                  lives_d     = LIVES_INIT;
                  skillPts_d  = PTS_INIT;
                  loadStage_d = 1'b1;
               end
            end

            PLAY: begin
               if (flowBus.bricks_empty) begin
                  if (stage_q >= LAST_STAGE) begin
                     state_d = WIN;
                  end else begin
                     state_d    = CLEAR;
                     clearCnt_d = '0;
                  end
               end else if (flowBus.ball_lost) begin
                  if (lives_q <= 3'd1) begin
                     lives_d = 3'd0;
                     state_d = LOSE;
                  end else begin
                     lives_d = lives_q - 3'd1;
                  end
`ifdef PAUSE_EN
               end else if (flowBus.pause_press) begin
                  state_d = PAUSE;
`endif
               end else if ((skillPts_q != 3'd0) && (eligible != '0)) begin
                  skillGrant_d = lowestEligible;
                  skillPts_d   = skillPts_q - 3'd1;
               end
            end

            CLEAR: begin
               if (clearCnt_q >= CLEAR_LAST) begin
                  state_d     = PLAY;
                  clearCnt_d  = '0;
                  loadStage_d = 1'b1;
                  if (stage_q != 4'hF) begin
                     stage_d = stage_q + 4'd1;
                  end
                  if (skillPts_q < PTS_INIT) begin
                     skillPts_d = skillPts_q + 3'd1;
                  end
               end else begin
                  clearCnt_d = clearCnt_q + CNT_W'(1);
               end
            end

            WIN, LOSE: begin
               if (flowBus.start_press) begin
                  state_d = MENU;
               end
            end

`ifdef PAUSE_EN
            PAUSE: begin
               if (flowBus.pause_press) begin
                  state_d = PLAY;
               end
            end
`endif

            default: begin
               state_d = MENU;
            end
         endcase

         if (state_d == PAUSE) begin
            led_d = led_q;
         end else begin
            led_d = composeLed(state_d, stage_d, lives_d, skillPts_d);
         end
      end
   end

   // State and registered outputs; reset is synchronous and overrides tick
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= MENU;
         stage_q      <= 4'd0;
         lives_q      <= LIVES_INIT;
         skillPts_q   <= PTS_INIT;
         skillGrant_q <= '0;
         loadStage_q  <= 1'b0;
         led_q        <= 16'd0;
         clearCnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         stage_q      <= stage_d;
         lives_q      <= lives_d;
         skillPts_q   <= skillPts_d;
         skillGrant_q <= skillGrant_d;
         loadStage_q  <= loadStage_d;
         led_q        <= led_d;
         clearCnt_q   <= clearCnt_d;
      end
   end

   // Every output comes straight from a register
   assign flowBus.state       = state_q;
   assign flowBus.stage       = stage_q;
   assign flowBus.lives       = lives_q;
   assign flowBus.skill_pts   = skillPts_q;
   assign flowBus.skill_grant = skillGrant_q;
   assign flowBus.load_stage  = loadStage_q;
   assign flowBus.led         = led_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: a rule-level game model runs in
// parallel with the DUT and every output is compared on every cycle, with
// directed scenarios and literal spot checks along the way.
module tb_game_flow_ctrl;

   localparam int NUM_STAGES   = 3;
   localparam int LIVES        = 5;
   localparam int SKILL_POINTS = 3;
   localparam int SKILL_CH     = 3;
   localparam int CLEAR_TICKS  = 20;

`ifdef PAUSE_EN
   localparam bit HAS_PAUSE = 1'b1;
`else
   localparam bit HAS_PAUSE = 1'b0;
`endif

   // Game states as the outside world sees them
   localparam int S_MENU  = 0;
   localparam int S_WIN   = 1;
   localparam int S_LOSE  = 2;
   localparam int S_PLAY  = 3;
   localparam int S_CLEAR = 4;
   localparam int S_PAUSE = 5;

   typedef struct {
      int st;
      int stage;
      int lives;
      int pts;
      int remain;
      int grant;
      int load;
   } model_t;

   logic   clk = 1'b0;
   logic   rst;
   int     errors = 0;
   int     checks = 0;
   bit     checkEn = 1'b0;
   model_t m;

   game_flow_ctrl_if #(.SKILL_CH(SKILL_CH)) bus();

   game_flow_ctrl #(
      .NUM_STAGES  (NUM_STAGES),
      .LIVES       (LIVES),
      .SKILL_POINTS(SKILL_POINTS),
      .SKILL_CH    (SKILL_CH),
      .CLEAR_TICKS (CLEAR_TICKS)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .flowBus(bus)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   function automatic model_t modelReset();
      model_t r;
      r.st     = S_MENU;
      r.stage  = 0;
      r.lives  = LIVES;
      r.pts    = SKILL_POINTS;
      r.remain = 0;
      r.grant  = 0;
      r.load   = 0;
      return r;
   endfunction

   // Game rules applied once per clock: CLEAR is tracked as ticks remaining
   function automatic model_t modelNext(input model_t cur, input bit tk, input bit start,
                                        input bit pause, input bit bricks, input bit lost,
                                        input logic [SKILL_CH-1:0] req,
                                        input logic [SKILL_CH-1:0] act);
      model_t n;
      n       = cur;
      n.grant = 0;
      n.load  = 0;
      if (!tk) return n;
      if (cur.st == S_MENU) begin
         if (start) begin
            n.st    = S_PLAY;
            n.stage = 0;
            n.lives = LIVES;
            n.pts   = SKILL_POINTS;
            n.load  = 1;
         end
      end else if (cur.st == S_PLAY) begin
         if (bricks) begin
            if (cur.stage == NUM_STAGES - 1) n.st = S_WIN;
            else begin
               n.st     = S_CLEAR;
               n.remain = CLEAR_TICKS;
            end
         end else if (lost) begin
            n.lives = (cur.lives > 0) ? cur.lives - 1 : 0;
            if (n.lives == 0) n.st = S_LOSE;
         end else if (HAS_PAUSE && pause) begin
            n.st = S_PAUSE;
         end else if (cur.pts > 0) begin
            for (int i = 0; i < SKILL_CH; i++) begin
               if (req[i] && !act[i] && n.grant == 0) begin
                  n.grant = 1 << i;
                  n.pts   = cur.pts - 1;
               end
            end
         end
      end else if (cur.st == S_CLEAR) begin
         n.remain = cur.remain - 1;
         if (n.remain == 0) begin
            n.st    = S_PLAY;
            n.stage = (cur.stage < 15) ? cur.stage + 1 : 15;
            n.load  = 1;
            n.pts   = (cur.pts + 1 > SKILL_POINTS) ? SKILL_POINTS : cur.pts + 1;
         end
      end else if (cur.st == S_WIN || cur.st == S_LOSE) begin
         if (start) n.st = S_MENU;
      end else if (cur.st == S_PAUSE) begin
         if (pause) n.st = S_PLAY;
      end
      return n;
   endfunction

   // LED word derived arithmetically from the game situation
   function automatic int expLed(input model_t cur);
      int v;
      if (cur.st == S_MENU) return 0;
      v = (1 << cur.lives) - 1;
      if (cur.st == S_LOSE) v = v + 64;
      if (cur.st == S_WIN)  v = v + 128;
      v = v + (cur.stage << 8);
      v = v + (((15 << (4 - cur.pts)) & 15) << 12);
      return v;
   endfunction

   // Model advances on the same edge as the DUT
   always @(posedge clk) begin
      if (rst) m <= modelReset();
      else     m <= modelNext(m, bus.tick, bus.start_press, bus.pause_press, bus.bricks_empty,
                              bus.ball_lost, bus.skill_req, bus.skill_active);
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Cycle-by-cycle comparison of every DUT output against the model
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("cyc_state", 32'(bus.state), 32'(m.st));
         checkOutput("cyc_stage", 32'(bus.stage), 32'(m.stage));
         checkOutput("cyc_lives", 32'(bus.lives), 32'(m.lives));
         checkOutput("cyc_skill_pts", 32'(bus.skill_pts), 32'(m.pts));
         checkOutput("cyc_skill_grant", 32'(bus.skill_grant), 32'(m.grant));
         checkOutput("cyc_load_stage", 32'(bus.load_stage), 32'(m.load));
         checkOutput("cyc_led", 32'(bus.led), 32'(expLed(m)));
      end
   end

   task automatic applyStimulus(input bit tk, input bit start, input bit pause,
                                input bit bricks, input bit lost,
                                input logic [SKILL_CH-1:0] req,
                                input logic [SKILL_CH-1:0] act, input int cycles);
      bus.tick         = tk;
      bus.start_press  = start;
      bus.pause_press  = pause;
      bus.bricks_empty = bricks;
      bus.ball_lost    = lost;
      bus.skill_req    = req;
      bus.skill_active = act;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic idle(input int cycles);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, cycles);
   endtask

   // Directed scenario sequence with literal spot checks
   initial begin
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 2);
      rst = 1'b0;
      checkEn = 1'b1;
      checkOutput("reset_state", 32'(bus.state), 32'd0);
      checkOutput("reset_lives", 32'(bus.lives), 32'd5);
      checkOutput("reset_pts", 32'(bus.skill_pts), 32'd3);
      checkOutput("reset_led", 32'(bus.led), 32'd0);

      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1);
      checkOutput("start_state", 32'(bus.state), 32'd3);
      checkOutput("start_load", 32'(bus.load_stage), 32'd1);
      checkOutput("start_led", 32'(bus.led), 32'hE01F);
      checkOutput("model_start_led", 32'(expLed(m)), 32'hE01F);
      idle(1);
      checkOutput("load_drop", 32'(bus.load_stage), 32'd0);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b001, 1);
      checkOutput("grant_skip_active", 32'(bus.skill_grant), 32'b010);
      checkOutput("grant_pts", 32'(bus.skill_pts), 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 1);
      checkOutput("grant_pulse_end", 32'(bus.skill_grant), 32'd0);
      checkOutput("notick_pts", 32'(bus.skill_pts), 32'd2);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 1);
      checkOutput("grant_ch0", 32'(bus.skill_grant), 32'b001);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 3'b010, 1);
      checkOutput("grant_ch2", 32'(bus.skill_grant), 32'b100);
      checkOutput("pts_zero", 32'(bus.skill_pts), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 1);
      checkOutput("no_grant_at_zero", 32'(bus.skill_grant), 32'd0);
      checkOutput("led_pts_zero", 32'(bus.led), 32'h001F);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1);
      checkOutput("notick_lives", 32'(bus.lives), 32'd5);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0, '0, 1);
      checkOutput("both_state", 32'(bus.state), 32'd4);
      checkOutput("both_lives", 32'(bus.lives), 32'd5);
      idle(CLEAR_TICKS - 1);
      checkOutput("clear_hold", 32'(bus.state), 32'd4);
      idle(1);
      checkOutput("clear_exit", 32'(bus.state), 32'd3);
      checkOutput("clear_stage", 32'(bus.stage), 32'd1);
      checkOutput("clear_load", 32'(bus.load_stage), 32'd1);
      checkOutput("clear_refill", 32'(bus.skill_pts), 32'd1);

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1);
      idle(CLEAR_TICKS);
      checkOutput("stage2", 32'(bus.stage), 32'd2);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1);
      checkOutput("win_state", 32'(bus.state), 32'd1);
      checkOutput("win_led", 32'(bus.led), 32'hC29F);
      checkOutput("model_win_led", 32'(expLed(m)), 32'hC29F);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1);
      checkOutput("win_ignores_lost", 32'(bus.lives), 32'd5);

      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1);
      checkOutput("menu_led", 32'(bus.led), 32'd0);
      checkOutput("menu_keeps_stage", 32'(bus.stage), 32'd2);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1);
      checkOutput("replay_stage", 32'(bus.stage), 32'd0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1);
         checkOutput("lost_lives", 32'(bus.lives), 32'(4 - i));
      end
      checkOutput("lose_state", 32'(bus.state), 32'd2);
      checkOutput("lose_led", 32'(bus.led), 32'hE040);
      idle(1);
      checkOutput("lose_lives_floor", 32'(bus.lives), 32'd0);

      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1);
      idle(5);
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1);
      rst = 1'b0;
      checkOutput("rst_clear_state", 32'(bus.state), 32'd0);
      checkOutput("rst_clear_stage", 32'(bus.stage), 32'd0);
      checkOutput("rst_clear_lives", 32'(bus.lives), 32'd5);
      checkOutput("rst_clear_led", 32'(bus.led), 32'd0);

      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, '0, 1);
      checkOutput("pause_state", 32'(bus.state), HAS_PAUSE ? 32'd5 : 32'd3);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1);
      checkOutput("pause_lives", 32'(bus.lives), HAS_PAUSE ? 32'd5 : 32'd4);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1);
      checkOutput("resume_state", 32'(bus.state), 32'd3);
      idle(3);

      checkEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
